// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data port.
// Accepts one word-addressed load/store at a time and applies the byte-lane
// strobes to an internal word array. It returns the post-write word after
// LATENCY wait cycles over a valid/ready handshake.
// Optional feature macro: DMEM_RANGE_CHK_EN. When it is defined, requests with
// nonzero address bits above the array are flagged with resp_err, and their
// writes are dropped. When it is undefined, upper address bits alias.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_strb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] req_idx_s;
  logic              err_r;
  logic              req_err_s;
  logic [2:0]        cnt_r;
  logic [2:0]        cnt_nxt_s;
  logic              req_hs_s;
  logic              resp_hs_s;
  logic [31:0]       merged_s;
  logic              req_ready_nxt_s;
  logic              resp_valid_nxt_s;
  logic [31:0]       resp_rdata_nxt_s;
  logic              resp_err_nxt_s;
  logic              unused_addr_s;

  // Replace each strobed byte lane of old_word with the same lane of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign req_idx_s     = req_addr[ADDR_W+1:2];
  assign req_hs_s      = req_valid && (state_r == ST_IDLE);
  assign resp_hs_s     = resp_valid && resp_ready;
  assign merged_s      = merge_lanes(mem_r[req_idx_s], req_wdata, req_strb);
  // Byte-offset bits never select anything; upper bits only feed the range check.
  assign unused_addr_s = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};

`ifdef DMEM_RANGE_CHK_EN
  assign req_err_s = (req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`else
  assign req_err_s = 1'b0;
`endif

  // Word array: commit strobed lanes at the accepting edge (never reset).
  always_ff @(posedge clk) begin
    if (req_hs_s && !req_err_s) begin
      mem_r[req_idx_s] <= merged_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_hs_s) begin
          state_nxt_s = ZERO_LAT ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs and wait counter.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    resp_valid_nxt_s = resp_valid;
    resp_rdata_nxt_s = resp_rdata;
    resp_err_nxt_s   = resp_err;
    req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (req_hs_s) begin
          cnt_nxt_s = CNT_LOAD;
          if (ZERO_LAT) begin
            // RESP entered at the accepting edge: bypass the array write.
            resp_valid_nxt_s = 1'b1;
            resp_rdata_nxt_s = req_err_s ? 32'h0000_0000 : merged_s;
            resp_err_nxt_s   = req_err_s;
          end else begin
            resp_valid_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          resp_valid_nxt_s = 1'b1;
          resp_rdata_nxt_s = err_r ? 32'h0000_0000 : mem_r[idx_r];
          resp_err_nxt_s   = err_r;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_RESP: begin
        if (resp_hs_s) begin
          resp_valid_nxt_s = 1'b0;
          resp_err_nxt_s   = 1'b0;
        end else begin
          resp_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        resp_valid_nxt_s = 1'b0;
        resp_err_nxt_s   = 1'b0;
      end
    endcase
  end

  // Output, counter and request-capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      cnt_r      <= 3'd0;
      idx_r      <= {ADDR_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      req_ready  <= req_ready_nxt_s;
      resp_valid <= resp_valid_nxt_s;
      resp_rdata <= resp_rdata_nxt_s;
      resp_err   <= resp_err_nxt_s;
      cnt_r      <= cnt_nxt_s;
      if (req_hs_s) begin
        idx_r <= req_idx_s;
        err_r <= req_err_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 7), a directed
// vector table, hand-written back-pressure and reset sequences, and a random
// phase checked against a word-level model of the array.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [3:0]  req_strb   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int total = 0;
  int bad   = 0;
  int lat_of [3] = '{2, 1, 8};
  logic [31:0] mdl [int];

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_strb(req_strb[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_strb(req_strb[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_responder #(.ADDR_W(10), .LATENCY(7)) u_dut_l7 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_strb(req_strb[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: out-of-range only when the range check is compiled in.
  function automatic bit mdl_err(input logic [31:0] addr);
`ifdef DMEM_RANGE_CHK_EN
    return (addr / 32'd4096) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mdl_key(input int d, input logic [31:0] addr);
    return d * 1024 + int'((addr / 32'd4) % 32'd1024);
  endfunction

  // Model: word after applying the strobed bytes to the stored word.
  function automatic logic [31:0] mdl_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
    logic [31:0] res;
    logic [31:0] byte_v;
    res = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) byte_v = (new_w >> (8 * i)) & 32'hFF;
      else         byte_v = (old_w >> (8 * i)) & 32'hFF;
      res = res + (byte_v << (8 * i));
    end
    return res;
  endfunction

  // One full transaction on instance d with hold cycles of back-pressure.
  task automatic run(input int d, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int lat;
    logic [31:0] first_rdata;
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_addr[d]   = addr;
    req_strb[d]   = strb;
    req_wdata[d]  = wdata;
    resp_ready[d] = (hold == 0);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(lat_of[d]));
    check({tag, " rdata"}, resp_rdata[d], exp_rdata);
    check({tag, " err"}, 32'(resp_err[d]), 32'(exp_err));
    check({tag, " req_ready busy"}, 32'(req_ready[d]), 32'd0);
    first_rdata = resp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " bp valid"}, 32'(resp_valid[d]), 32'd1);
      check({tag, " bp rdata"}, resp_rdata[d], first_rdata);
      check({tag, " bp req_ready"}, 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " valid after hs"}, 32'(resp_valid[d]), 32'd0);
    check({tag, " req_ready after hs"}, 32'(req_ready[d]), 32'd1);
    check({tag, " err after hs"}, 32'(resp_err[d]), 32'd0);
    resp_ready[d] = 1'b0;
    if (!mdl_err(addr)) begin
      mdl[mdl_key(d, addr)] = mdl_merge(mdl.exists(mdl_key(d, addr)) ? mdl[mdl_key(d, addr)] : 32'd0,
                                        wdata, strb);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] e;
    logic [3:0]  s;
    int k;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = 32'd0; req_strb[d] = 4'd0;
      req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset req_ready", 32'(req_ready[d]), 32'd1);
      check("reset resp_valid", 32'(resp_valid[d]), 32'd0);
      check("reset resp_rdata", resp_rdata[d], 32'd0);
      check("reset resp_err", 32'(resp_err[d]), 32'd0);
    end

    // Directed vectors.
    vecs.push_back('{0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 32'h10, 4'h0, 32'h0,       0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 32'h40, 4'hF, 32'h11223344, 0, 32'h11223344, 1'b0});
    vecs.push_back('{0, 32'h40, 4'h4, 32'h00AA0000, 0, 32'h11AA3344, 1'b0});
    vecs.push_back('{0, 32'h40, 4'h1, 32'h000000BB, 0, 32'h11AA33BB, 1'b0});
    vecs.push_back('{0, 32'h40, 4'h0, 32'h0,       0, 32'h11AA33BB, 1'b0});
    vecs.push_back('{0, 32'h43, 4'h0, 32'h0,       0, 32'h11AA33BB, 1'b0});
    vecs.push_back('{0, 32'h44, 4'hF, 32'hAABBCCDD, 0, 32'hAABBCCDD, 1'b0});
    vecs.push_back('{0, 32'h44, 4'h5, 32'h11223344, 0, 32'hAA22CC44, 1'b0});
    vecs.push_back('{0, 32'h10, 4'h0, 32'h0,       5, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 32'h0,  4'hF, 32'h01020304, 0, 32'h01020304, 1'b0});
`ifdef DMEM_RANGE_CHK_EN
    vecs.push_back('{0, 32'h1000, 4'hF, 32'h55667788, 0, 32'h00000000, 1'b1});
    vecs.push_back('{0, 32'h0,    4'h0, 32'h0,        0, 32'h01020304, 1'b0});
`else
    vecs.push_back('{0, 32'h1000, 4'hF, 32'h55667788, 0, 32'h55667788, 1'b0});
    vecs.push_back('{0, 32'h0,    4'h0, 32'h0,        0, 32'h55667788, 1'b0});
`endif
    vecs.push_back('{1, 32'h8,  4'hF, 32'h12345678, 0, 32'h12345678, 1'b0});
    vecs.push_back('{1, 32'h8,  4'h2, 32'h0000EE00, 2, 32'h1234EE78, 1'b0});
    vecs.push_back('{2, 32'h8,  4'hF, 32'h9ABCDEF0, 0, 32'h9ABCDEF0, 1'b0});
    vecs.push_back('{2, 32'h8,  4'h0, 32'h0,       3, 32'h9ABCDEF0, 1'b0});
    foreach (vecs[i]) begin
      run(vecs[i].d, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].hold,
          vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset during WAIT: outputs drop at once, committed write survives.
    @(negedge clk);
    req_valid[2] = 1'b1; req_addr[2] = 32'h20; req_strb[2] = 4'hF;
    req_wdata[2] = 32'hCAFEF00D; resp_ready[2] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    mdl[mdl_key(2, 32'h20)] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst resp_valid", 32'(resp_valid[2]), 32'd0);
    check("midrst req_ready", 32'(req_ready[2]), 32'd1);
    check("midrst resp_rdata", resp_rdata[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst no late resp", 32'(resp_valid[2]), 32'd0);
    run(2, 32'h20, 4'h0, 32'h0, 0, 32'hCAFEF00D, 1'b0, "midrst read");

    // Random phase: preload a small pool, then random mixed traffic.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        w = $urandom;
        run(d, 32'(i * 4), 4'hF, w, 0, w, 1'b0, "preload");
      end
      for (int n = 0; n < 40; n++) begin
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3) * 4096);
        s = 4'($urandom_range(0, 15));
        w = $urandom;
        k = mdl_key(d, a);
        e = mdl_err(a) ? 32'd0 : mdl_merge(mdl[k], w, s);
        run(d, a, s, w, $urandom_range(0, 2), e, mdl_err(a), $sformatf("rand d%0d n%0d", d, n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
